// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter and its slots.
// Slot struct widths match the arbiter's default address/data widths.
package regfile_arb_pkg;

    localparam int SRC_CPU = 0;
    localparam int SRC_OSC = 1;
    localparam int SRC_DBG = 2;

    localparam int DEFAULT_MAX_WAIT = 4;

    localparam int ARB_AW = 4;
    localparam int ARB_DW = 8;
    localparam int WAIT_W = 4;

    typedef struct packed {
        logic              full;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] data;
        logic [WAIT_W-1:0] wait_cnt;
    } slot_t;

endpackage

// File: rtl/arb_slot.sv
// One-entry write holding slot; ready = empty or being granted, so a winner refills back-to-back.
// Optional saturating wait counter for aging under REGFILE_ARB_AGING_EN.
module arb_slot
    import regfile_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clock,
    input  logic              isReset,
    input  logic              load,
    input  logic              grant,
    input  logic [ARB_AW-1:0] load_addr,
    input  logic [ARB_DW-1:0] load_data,
    output logic              ready,
    output logic              full,
    output logic [ARB_AW-1:0] addr,
    output logic [ARB_DW-1:0] data,
    output logic              aged
);

    slot_t st;
    logic [WAIT_W-1:0] wait_next;

    assign ready = !st.full || grant;
    assign full  = st.full;
    assign addr  = st.addr;
    assign data  = st.data;
    assign aged  = st.full && (st.wait_cnt >= WAIT_W'(MAX_WAIT));

    always_comb begin
        wait_next = '0;
`ifdef REGFILE_ARB_AGING_EN
        // A fresh entry starts young even if it replaced a granted one.
        if (load || grant || !st.full) begin
            wait_next = '0;
        end else if (st.wait_cnt != '1) begin
            wait_next = st.wait_cnt + 1'b1;
        end else begin
            wait_next = st.wait_cnt;
        end
`endif
    end

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            st <= '0;
        end else begin
            if (load) begin
                st.full <= 1'b1;
                st.addr <= load_addr;
                st.data <= load_data;
            end else if (grant) begin
                st.full <= 1'b0;
            end
            st.wait_cnt <= wait_next;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between CPU, oscillator sampler and debug; one registered write per cycle.
// Fixed priority (lowest index wins); aged slots first when REGFILE_ARB_AGING_EN is defined.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ          = 3,
    parameter int REGISTER_WIDTH   = ARB_DW,
    parameter int LOG_OF_REGISTERS = ARB_AW,
    parameter int MAX_WAIT         = DEFAULT_MAX_WAIT
) (
    input  logic                                 clock,
    input  logic                                 isReset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*LOG_OF_REGISTERS-1:0]  req_addr,
    input  logic [NUM_REQ*REGISTER_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 wr_en,
    output logic [LOG_OF_REGISTERS-1:0]          wr_addr,
    output logic [REGISTER_WIDTH-1:0]            wr_data,
    output logic [1:0]                           wr_src,
    output logic                                 collision
);

    logic [NUM_REQ-1:0]          full;
    logic [NUM_REQ-1:0]          aged;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          cand;
    logic [LOG_OF_REGISTERS-1:0] slot_addr [NUM_REQ];
    logic [REGISTER_WIDTH-1:0]   slot_data [NUM_REQ];

    logic                        win_vld;
    logic [1:0]                  win_idx;
    logic [LOG_OF_REGISTERS-1:0] win_addr;
    logic [REGISTER_WIDTH-1:0]   win_data;
    logic                        collide;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        arb_slot #(
            .MAX_WAIT (MAX_WAIT)
        ) u_slot (
            .clock     (clock),
            .isReset   (isReset),
            .load      (req_valid[gi] && req_ready[gi]),
            .grant     (grant[gi]),
            .load_addr (req_addr[gi*LOG_OF_REGISTERS +: LOG_OF_REGISTERS]),
            .load_data (req_data[gi*REGISTER_WIDTH +: REGISTER_WIDTH]),
            .ready     (req_ready[gi]),
            .full      (full[gi]),
            .addr      (slot_addr[gi]),
            .data      (slot_data[gi]),
            .aged      (aged[gi])
        );
    end

    always_comb begin
        grant    = '0;
        win_vld  = 1'b0;
        win_idx  = 2'(SRC_CPU);
        win_addr = '0;
        win_data = '0;
        collide  = 1'b0;
        // Aged slots (never set without aging) pre-empt the plain priority order.
        cand     = (|aged) ? aged : full;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand[i] && !win_vld) begin
                win_vld  = 1'b1;
                win_idx  = 2'(i);
                win_addr = slot_addr[i];
                win_data = slot_data[i];
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full[i] && !grant[i] && (slot_addr[i] == win_addr)) begin
                collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_src    <= 2'(SRC_CPU);
            collision <= 1'b0;
        end else begin
            wr_en     <= win_vld;
            collision <= collide;
            if (win_vld) begin
                wr_addr <= win_addr;
                wr_data <= win_data;
                wr_src  <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with per-source write scoreboard.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        isReset;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  wr_src;
    logic        collision;

    int n_chk = 0;
    int n_fail = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] q2[$];

    logic [11:0] mon_exp;
    logic        mon_have;
    int          osc_seen;

    regfile_write_arbiter dut (
        .clock     (clock),
        .isReset   (isReset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .collision (collision)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic [2:0] v,
                       input logic [3:0] a0, input logic [7:0] d0,
                       input logic [3:0] a1, input logic [7:0] d1,
                       input logic [3:0] a2, input logic [7:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        if (v[0] && req_ready[0]) q0.push_back({a0, d0});
        if (v[1] && req_ready[1]) q1.push_back({a1, d1});
        if (v[2] && req_ready[2]) q2.push_back({a2, d2});
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(3'b000, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00);
    endtask

    // Every issued write must match the oldest accepted entry of its source.
    always @(negedge clock) begin
        if (!isReset && wr_en) begin
            mon_have = 1'b0;
            case (wr_src)
                2'd0: if (q0.size() > 0) begin mon_exp = q0.pop_front(); mon_have = 1'b1; end
                2'd1: if (q1.size() > 0) begin mon_exp = q1.pop_front(); mon_have = 1'b1; end
                2'd2: if (q2.size() > 0) begin mon_exp = q2.pop_front(); mon_have = 1'b1; end
                default: mon_have = 1'b0;
            endcase
            n_chk++;
            assert (mon_have) else begin
                n_fail++;
                $error("FAIL wr_unexpected: src %0d wrote addr %0h data %0h with nothing pending, expected no write",
                       wr_src, wr_addr, wr_data);
            end
            if (mon_have) chk("wr_payload", {20'h0, wr_addr, wr_data}, {20'h0, mon_exp});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        isReset   = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_wr_en",     {31'h0, wr_en}, 32'h0);
        chk("rst_wr_addr",   {28'h0, wr_addr}, 32'h0);
        chk("rst_wr_data",   {24'h0, wr_data}, 32'h0);
        chk("rst_wr_src",    {30'h0, wr_src}, 32'h0);
        chk("rst_collision", {31'h0, collision}, 32'h0);
        chk("rst_ready",     {29'h0, req_ready}, 32'h7);
        isReset = 1'b0;

        // Single CPU write
        chk("t1_ready_pre", {31'h0, req_ready[0]}, 32'h1);
        cyc(3'b001, 4'h3, 8'h5A, 4'h0, 8'h00, 4'h0, 8'h00);
        chk("t1_wr_en_e0", {31'h0, wr_en}, 32'h0);
        chk("t1_ready_e0", {31'h0, req_ready[0]}, 32'h1);
        idle();
        chk("t1_wr_en_e1", {31'h0, wr_en}, 32'h1);
        chk("t1_addr",     {28'h0, wr_addr}, 32'h3);
        chk("t1_data",     {24'h0, wr_data}, 32'h5A);
        chk("t1_src",      {30'h0, wr_src}, 32'h0);
        chk("t1_ready_e1", {31'h0, req_ready[0]}, 32'h1);
        idle();
        chk("t1_wr_en_e2", {31'h0, wr_en}, 32'h0);

        // CPU and oscillator together: CPU first
        cyc(3'b011, 4'h2, 8'h11, 4'h9, 8'hD8, 4'h0, 8'h00);
        chk("t2_osc_ready_e0", {31'h0, req_ready[1]}, 32'h0);
        idle();
        chk("t2_wr_en_e1", {31'h0, wr_en}, 32'h1);
        chk("t2_src_e1",   {30'h0, wr_src}, 32'h0);
        chk("t2_addr_e1",  {28'h0, wr_addr}, 32'h2);
        idle();
        chk("t2_wr_en_e2", {31'h0, wr_en}, 32'h1);
        chk("t2_src_e2",   {30'h0, wr_src}, 32'h1);
        chk("t2_data_e2",  {24'h0, wr_data}, 32'hD8);
        idle();
        chk("t2_wr_en_e3", {31'h0, wr_en}, 32'h0);

        // CPU and debug on the same address
        cyc(3'b101, 4'h5, 8'hA1, 4'h0, 8'h00, 4'h5, 8'hB2);
        chk("t3_coll_e0", {31'h0, collision}, 32'h0);
        idle();
        chk("t3_coll_e1", {31'h0, collision}, 32'h1);
        chk("t3_src_e1",  {30'h0, wr_src}, 32'h0);
        chk("t3_data_e1", {24'h0, wr_data}, 32'hA1);
        idle();
        chk("t3_coll_e2", {31'h0, collision}, 32'h0);
        chk("t3_src_e2",  {30'h0, wr_src}, 32'h2);
        chk("t3_data_e2", {24'h0, wr_data}, 32'hB2);
        idle();

        // CPU streaming while oscillator waits
        osc_seen = -1;
        cyc(3'b011, 4'h1, 8'h40, 4'h9, 8'h77, 4'h0, 8'h00);
        if (wr_en && wr_src == 2'd1 && osc_seen < 0) osc_seen = 0;
        for (int k = 1; k < 8; k++) begin
            cyc(3'b001, 4'h1, 8'(8'h40 + k), 4'h0, 8'h00, 4'h0, 8'h00);
            if (wr_en && wr_src == 2'd1 && osc_seen < 0) osc_seen = k;
        end
`ifdef REGFILE_ARB_AGING_EN
        chk("t4_osc_aged_edge", osc_seen, 32'd5);
`else
        chk("t4_osc_starved", osc_seen, 32'hFFFF_FFFF);
        idle();
        chk("t4_src_e8", {30'h0, wr_src}, 32'h0);
        idle();
        chk("t4_wr_en_e9", {31'h0, wr_en}, 32'h1);
        chk("t4_src_e9",   {30'h0, wr_src}, 32'h1);
`endif
        for (int k = 0; k < 3; k++) idle();
        chk("t4_drained", {31'h0, wr_en}, 32'h0);

        // Reset while all three slots hold entries
        cyc(3'b111, 4'h1, 8'h01, 4'h2, 8'h02, 4'h3, 8'h03);
        chk("t5_ready_full", {29'h0, req_ready}, 32'h1);
        idle();
        chk("t5_wr_en_pre", {31'h0, wr_en}, 32'h1);
        #2;
        isReset = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        q2.delete();
        chk("t5_wr_en_rst",   {31'h0, wr_en}, 32'h0);
        chk("t5_ready_rst",   {29'h0, req_ready}, 32'h7);
        chk("t5_wr_addr_rst", {28'h0, wr_addr}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        isReset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t5_no_write", {31'h0, wr_en}, 32'h0);
        end

        // Debug stream of 16 back-to-back writes
        for (int k = 0; k < 16; k++) begin
            chk("t6_dbg_ready", {31'h0, req_ready[2]}, 32'h1);
            cyc(3'b100, 4'h0, 8'h00, 4'h0, 8'h00, 4'(k), 8'(8'hC0 + k));
            if (k == 0) begin
                chk("t6_wr_en_first", {31'h0, wr_en}, 32'h0);
            end else begin
                chk("t6_wr_en", {31'h0, wr_en}, 32'h1);
                chk("t6_data",  {24'h0, wr_data}, 32'(8'hC0 + k - 1));
            end
        end
        idle();
        chk("t6_wr_en_last", {31'h0, wr_en}, 32'h1);
        chk("t6_data_last",  {24'h0, wr_data}, 32'hCF);
        idle();
        chk("t6_wr_en_end",  {31'h0, wr_en}, 32'h0);

        chk("q0_empty", q0.size(), 32'h0);
        chk("q1_empty", q1.size(), 32'h0);
        chk("q2_empty", q2.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single CPU register-file write port among several requesters: CPU ALU/load writeback, the oscillator position sampler (today hard-wired to register 9), and a debug/monitor port. Each requester hands over (address, data) with a valid/ready handshake into a one-entry slot. A fixed-priority arbiter, with optional aging, issues at most one registered write per cycle to the register array.

## Interface
- `NUM_REQ`, 3, number of requesters; index 0 = CPU writeback, 1 = oscillator sampler, 2 = debug.
- `REGISTER_WIDTH`, 8, data width.
- `LOG_OF_REGISTERS`, 4, register address width.
- `MAX_WAIT`, 4, aging threshold in cycles (1..15).
- `clock`  in  1  sole clock, rising edge.
- `isReset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ*LOG_OF_REGISTERS  flattened addresses, requester i at slice i.
- `req_data`  in  NUM_REQ*REGISTER_WIDTH  flattened data.
- `req_ready`  out  NUM_REQ  slot i can accept this cycle.
- `wr_en`  out  1  registered write strobe to the register file.
- `wr_addr`  out  LOG_OF_REGISTERS  registered write address.
- `wr_data`  out  REGISTER_WIDTH  registered write data.
- `wr_src`  out  2  index of the requester whose write is on `wr_*`.
- `collision`  out  1  registered pulse: a losing pending slot targets the same address as the winner.

## Operation
- Slot i: `full`, addr, data. Handshake when `req_valid[i] && req_ready[i]` at an edge; slot loads and becomes full.
- `req_ready[i] = !full[i] || grant[i]`. Combinational from slot state only, never from `req_valid`. This allows back-to-back acceptance by the winner.
- Grant is combinational on slot state: the lowest-index full slot wins (CPU > oscillator > debug).
- At the edge, the granted slot's contents go to `wr_addr`/`wr_data`, `wr_en` ← 1, `wr_src` ← i, and the slot empties unless refilled the same edge.
- No full slot: `wr_en` ← 0; `wr_addr`/`wr_data`/`wr_src` hold.
- Simultaneous grant and new handshake on the same slot: the new entry is loaded and the slot stays full.
- `collision` ← 1 for one cycle when the winner's address equals the address of any other full slot. Both writes still issue, winner first. The arbiter does no merging or drop.
- Address and data are passed unmodified; no arithmetic on data.

## Timing
- Latency: handshake at edge E0, `wr_en` high from E1 at the earliest (1 cycle). The value is visible in the register file after E2.
- Throughput: 1 write/cycle in aggregate; a requester that keeps winning sustains 1/cycle.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_src`=0, `collision`=0, all slots empty, so `req_ready` = all ones.
- `isReset` asserted mid-operation: pending slots are discarded and `wr_en` drops immediately (asynchronous). A write in flight on that cycle is not guaranteed.
- First edge after reset release: normal operation; the handshake may occur on it.

## Configuration
- `REGFILE_ARB_AGING_EN` defined: each slot has a saturating wait counter.
  - The counter increments every cycle the slot is full and not granted, and clears on grant or when empty.
  - A slot with counter ≥ `MAX_WAIT` beats every non-aged slot; among aged slots the lowest index wins.
  - Worst-case wait for any slot is bounded by `MAX_WAIT` + `NUM_REQ` − 1 cycles.
- Undefined: pure fixed priority, no counters. A continuously valid CPU may starve slots 1..2 indefinitely.

## Structure
- Shared package `regfile_arb_pkg`:
  - requester index constants `SRC_CPU`=0, `SRC_OSC`=1, `SRC_DBG`=2;
  - the slot struct typedef (full, addr, data, wait);
  - the default `MAX_WAIT`.
- Sub-module `arb_slot`: one-entry holding slot with load/grant inputs, `ready` output, and the wait counter under the macro. Instantiate it `NUM_REQ` times; the priority/grant logic stays in the top.

## Test plan
- Reset, then CPU writes (addr 3, data 8'h5A) → `wr_en`=1 one cycle later with `wr_addr`=3, `wr_data`=8'h5A, `wr_src`=0; `req_ready[0]` stays 1 throughout.
- CPU and oscillator both valid on the same edge (CPU addr 2 = 8'h11, osc addr 9 = 8'hD8) → CPU write on E1, osc write on E2; `req_ready[1]`=0 during E1.
- CPU and debug both target addr 5 on the same edge → `collision`=1 for exactly one cycle; writes 5←CPU data then 5←debug data, in that order.
- Aging enabled with `MAX_WAIT`=4; CPU valid every cycle, osc valid once → osc granted within 4 cycles; without the macro, osc never granted while the CPU stays valid.
- Assert `isReset` while all three slots are full → `wr_en`=0 and `req_ready`=3'b111 immediately; no write issues after release until a new handshake.
- Debug streams 16 writes at 1/cycle with the other requesters idle → 16 consecutive `wr_en` cycles with no bubble and `wr_data` in order.
